tl_tx_arbiter: RTL and testbench

//  Tx-side TLP scheduler between the TL Tx FIFOs (P hdr/data, NP hdr, CPL hdr/data) and the DLL.
//  - Round-robins P, NP and CPL classes, gated by per-class credit-OK and link state.
//  - Serialises the winning TLP (header beat, then payload beats) onto tlp_o/req_o under tx_ready_i.
//  - Pops the FIFOs and pulses per-class sent strobes to the credit/payload counters.

---
 rtl/tl_pkg.sv | 44 ++++
 rtl/tl_rr_arb3.sv | 34 +++
 rtl/tl_tx_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_tl_tx_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tl_pkg
//  Purpose  : Shared types and header-field helpers for the TL Tx arbiter.
//             Header DW0 sits in bits [31:0] of the header vector:
//             Fmt[2:0] = [31:29], Length[9:0] = [9:0]. Fmt[1] (bit 30)
//             flags a TLP that carries payload.
//  Revision : 1.0  initial release
// ============================================================================
package tl_pkg;

  localparam int HDR_W            = 128;
  localparam int CPL_HDR_W        = 96;
  localparam int DATA_W           = 256;
  localparam int FMT_HAS_DATA_BIT = 30;
  localparam int HDR_LEN_W        = 10;

  // Request code presented to the DLL alongside each beat.
  typedef enum logic [2:0] {
    REQ_IDLE     = 3'd0,
    REQ_P_HDR    = 3'd1,
    REQ_P_DATA   = 3'd2,
    REQ_NP_HDR   = 3'd3,
    REQ_CPL_HDR  = 3'd5,
    REQ_CPL_DATA = 3'd6
  } req_t;

  // Traffic class; the value doubles as the round-robin slot index.
  typedef enum logic [1:0] {
    CLS_P   = 2'd0,
    CLS_NP  = 2'd1,
    CLS_CPL = 2'd2
  } cls_t;

  function automatic logic has_data(input logic [HDR_W-1:0] hdr);
    return hdr[FMT_HAS_DATA_BIT];
  endfunction

  function automatic logic [HDR_LEN_W-1:0] get_len(input logic [HDR_W-1:0] hdr);
    return hdr[HDR_LEN_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/tl_rr_arb3.sv
`default_nettype none
// ============================================================================
//  Module   : tl_rr_arb3
//  Purpose  : 3-way round-robin picker. Scans req_i starting at slot ptr_i
//             and wrapping, returns a one-hot grant of the first requester.
//  Ports    : req_i[2:0]   request per slot
//             ptr_i[1:0]   highest-priority slot this cycle (3 treated as 0)
//             grant_o[2:0] one-hot grant, zero when nothing requests
//  Revision : 1.0  initial release
// ============================================================================
module tl_rr_arb3 (
  input  logic [2:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [2:0] grant_o
);

  logic [1:0] w_idx;
  logic       w_found;

  always_comb begin
    grant_o = 3'b000;
    w_idx   = 2'd0;
    w_found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w_idx = 2'(({1'b0, ptr_i} + 3'(i)) % 3'd3);
      if (!w_found && req_i[w_idx]) begin
        grant_o[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tl_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tl_tx_arbiter
//  Purpose  : Tx TLP scheduler. Picks P/NP/CPL round-robin among classes with
//             credit, link up and a complete head TLP, then streams the header
//             beat and payload beats to the DLL under tx_ready_i, popping the
//             FWFT FIFOs and pulsing a sent strobe per completed P/CPL TLP.
//  Ports    : clk, rst (sync, active-high), link_active_i, tx_ready_i,
//             {p,np,cpl}_credit_ok_i, FWFT FIFO heads (empty/rdata/rden) for
//             P hdr/data, NP hdr, CPL hdr/data, tlp_o[255:0], req_o[2:0],
//             p_sent_o, cpl_sent_o.
//  Config   : TL_ARB_CPL_PRIORITY_EN - eligible CPL always wins; the pointer
//             then only rotates between P and NP.
//  Revision : 1.0  initial release
// ============================================================================
module tl_tx_arbiter
  import tl_pkg::*;
#(
  parameter int LEN_W      = 10,
  parameter int BEAT_CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         link_active_i,
  input  logic         tx_ready_i,
  input  logic         p_credit_ok_i,
  input  logic         np_credit_ok_i,
  input  logic         cpl_credit_ok_i,
  input  logic         p_hdr_empty_i,
  input  logic [127:0] p_hdr_rdata_i,
  output logic         p_hdr_rden_o,
  input  logic         p_data_empty_i,
  input  logic [255:0] p_data_rdata_i,
  output logic         p_data_rden_o,
  input  logic         np_hdr_empty_i,
  input  logic [127:0] np_hdr_rdata_i,
  output logic         np_hdr_rden_o,
  input  logic         cpl_hdr_empty_i,
  input  logic [95:0]  cpl_hdr_rdata_i,
  output logic         cpl_hdr_rden_o,
  input  logic         cpl_data_empty_i,
  input  logic [255:0] cpl_data_rdata_i,
  output logic         cpl_data_rden_o,
  output logic [255:0] tlp_o,
  output logic [2:0]   req_o,
  output logic         p_sent_o,
  output logic         cpl_sent_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                state_q, state_d;
  cls_t                  cls_q, cls_d;
  cls_t                  rr_ptr_q, rr_ptr_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [HDR_W-1:0]      w_cpl_hdr;
  logic [2:0]            w_elig;
  logic [2:0]            w_arb_req;
  logic [2:0]            w_grant;

  logic [HDR_W-1:0]      w_cur_hdr;
  logic [DATA_W-1:0]     w_cur_data;
  logic                  w_cur_data_empty;
  req_t                  w_hdr_code;
  req_t                  w_data_code;

  logic [LEN_W-1:0]      w_len;
  logic [LEN_W:0]        w_len_dw;
  logic [BEAT_CNT_W-1:0] w_beats_m1;

  req_t                  w_req;
  logic [DATA_W-1:0]     w_tlp;
  logic                  w_hdr_pop;
  logic                  w_data_pop;
  logic                  w_sent;

  assign w_cpl_hdr = {{(HDR_W-CPL_HDR_W){1'b0}}, cpl_hdr_rdata_i};

  // A class may only be picked when its whole head TLP can start: header
  // present, credit available and, for payload TLPs, at least one data beat.
  assign w_elig[CLS_P]   = link_active_i & p_credit_ok_i & ~p_hdr_empty_i &
                           (~has_data(p_hdr_rdata_i) | ~p_data_empty_i);
  assign w_elig[CLS_NP]  = link_active_i & np_credit_ok_i & ~np_hdr_empty_i;
  assign w_elig[CLS_CPL] = link_active_i & cpl_credit_ok_i & ~cpl_hdr_empty_i &
                           (~has_data(w_cpl_hdr) | ~cpl_data_empty_i);

`ifdef TL_ARB_CPL_PRIORITY_EN
  assign w_arb_req = w_elig[CLS_CPL] ? 3'b100 : {1'b0, w_elig[1:0]};
`else
  assign w_arb_req = w_elig;
`endif

  tl_rr_arb3 u_rr_arb3 (
    .req_i   (w_arb_req),
    .ptr_i   (rr_ptr_q),
    .grant_o (w_grant)
  );

  // Head-of-FIFO view for the class currently being transmitted.
  always_comb begin
    w_cur_hdr        = '0;
    w_cur_data       = '0;
    w_cur_data_empty = 1'b1;
    w_hdr_code       = REQ_IDLE;
    w_data_code      = REQ_IDLE;
    case (cls_q)
      CLS_P: begin
        w_cur_hdr        = p_hdr_rdata_i;
        w_cur_data       = p_data_rdata_i;
        w_cur_data_empty = p_data_empty_i;
        w_hdr_code       = REQ_P_HDR;
        w_data_code      = REQ_P_DATA;
      end
      CLS_NP: begin
        w_cur_hdr  = np_hdr_rdata_i;
        w_hdr_code = REQ_NP_HDR;
      end
      default: begin
        w_cur_hdr        = w_cpl_hdr;
        w_cur_data       = cpl_data_rdata_i;
        w_cur_data_empty = cpl_data_empty_i;
        w_hdr_code       = REQ_CPL_HDR;
        w_data_code      = REQ_CPL_DATA;
      end
    endcase
  end

  // Payload beats minus one; a zero Length field means 1024 DW.
  assign w_len      = LEN_W'(get_len(w_cur_hdr));
  assign w_len_dw   = (w_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, w_len};
  assign w_beats_m1 = BEAT_CNT_W'(((w_len_dw + (LEN_W+1)'(7)) >> 3) - (LEN_W+1)'(1));

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    w_req      = REQ_IDLE;
    w_tlp      = '0;
    w_hdr_pop  = 1'b0;
    w_data_pop = 1'b0;
    w_sent     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_grant != 3'b000) begin
          state_d = ST_HDR;
          if (w_grant[CLS_P]) begin
            cls_d    = CLS_P;
            rr_ptr_d = CLS_NP;
          end else if (w_grant[CLS_NP]) begin
            cls_d    = CLS_NP;
`ifdef TL_ARB_CPL_PRIORITY_EN
            rr_ptr_d = CLS_P;
`else
            rr_ptr_d = CLS_CPL;
`endif
          end else begin
            cls_d    = CLS_CPL;
`ifndef TL_ARB_CPL_PRIORITY_EN
            rr_ptr_d = CLS_P;
`endif
          end
        end
      end
      ST_HDR: begin
        w_req = w_hdr_code;
        w_tlp = {{(DATA_W-HDR_W){1'b0}}, w_cur_hdr};
        if (tx_ready_i) begin
          w_hdr_pop = 1'b1;
          if ((cls_q != CLS_NP) && has_data(w_cur_hdr)) begin
            state_d    = ST_DATA;
            beat_cnt_d = w_beats_m1;
          end else begin
            // Header-only P/CPL: the header is the last beat.
            state_d = ST_IDLE;
            w_sent  = (cls_q != CLS_NP);
          end
        end
      end
      ST_DATA: begin
        // Empty data FIFO leaves a bubble: IDLE code, zero beat, no pop.
        if (!w_cur_data_empty) begin
          w_req = w_data_code;
          w_tlp = w_cur_data;
          if (tx_ready_i) begin
            w_data_pop = 1'b1;
            if (beat_cnt_q == '0) begin
              state_d = ST_IDLE;
              w_sent  = 1'b1;
            end else begin
              beat_cnt_d = beat_cnt_q - BEAT_CNT_W'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cls_q      <= CLS_P;
      rr_ptr_q   <= CLS_P;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign req_o           = w_req;
  assign tlp_o           = w_tlp;
  assign p_hdr_rden_o    = w_hdr_pop  & (cls_q == CLS_P);
  assign np_hdr_rden_o   = w_hdr_pop  & (cls_q == CLS_NP);
  assign cpl_hdr_rden_o  = w_hdr_pop  & (cls_q == CLS_CPL);
  assign p_data_rden_o   = w_data_pop & (cls_q == CLS_P);
  assign cpl_data_rden_o = w_data_pop & (cls_q == CLS_CPL);
  assign p_sent_o        = w_sent     & (cls_q == CLS_P);
  assign cpl_sent_o      = w_sent     & (cls_q == CLS_CPL);

endmodule
`default_nettype wire

// File: tb/tb_tl_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_tl_tx_arbiter
//  Purpose  : Self-checking bench for tl_tx_arbiter. FIFOs are bench queues;
//             a transaction-level reference model predicts every beat.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tl_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, link, ready, p_cok, np_cok, c_cok;
  logic         p_he, p_de, np_he, c_he, c_de;
  logic [127:0] p_hd, np_hd;
  logic [95:0]  c_hd;
  logic [255:0] p_dd, c_dd;
  logic         p_hr, p_dr, np_hr, c_hr, c_dr, p_sent, c_sent;
  logic [255:0] tlp;
  logic [2:0]   req;

  tl_tx_arbiter dut (
    .clk(clk), .rst(rst), .link_active_i(link), .tx_ready_i(ready),
    .p_credit_ok_i(p_cok), .np_credit_ok_i(np_cok), .cpl_credit_ok_i(c_cok),
    .p_hdr_empty_i(p_he), .p_hdr_rdata_i(p_hd), .p_hdr_rden_o(p_hr),
    .p_data_empty_i(p_de), .p_data_rdata_i(p_dd), .p_data_rden_o(p_dr),
    .np_hdr_empty_i(np_he), .np_hdr_rdata_i(np_hd), .np_hdr_rden_o(np_hr),
    .cpl_hdr_empty_i(c_he), .cpl_hdr_rdata_i(c_hd), .cpl_hdr_rden_o(c_hr),
    .cpl_data_empty_i(c_de), .cpl_data_rdata_i(c_dd), .cpl_data_rden_o(c_dr),
    .tlp_o(tlp), .req_o(req), .p_sent_o(p_sent), .cpl_sent_o(c_sent)
  );

  int errors = 0;
  int checks = 0;

  // FIFO contents (class 0=P, 1=NP, 2=CPL); CPL headers stored zero-extended.
  logic [127:0] hq0[$], hq1[$], hq2[$];
  logic [255:0] dq0[$], dq2[$];
  int debt0 = 0, debt2 = 0;

  // Values sampled on the falling edge of the last step.
  logic [2:0]   s_req;
  logic [255:0] s_tlp;
  logic [4:0]   s_rd;    // {cpl_data, cpl_hdr, np_hdr, p_data, p_hdr}
  logic [1:0]   s_sent;  // {cpl, p}

  // Reference model: the TLP in flight is a pending header flag plus a count
  // of payload beats still owed.
  bit m_hp;
  int m_cls, m_left, m_ptr;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int hcnt(input int c);
    if (c == 0) return hq0.size();
    if (c == 1) return hq1.size();
    return hq2.size();
  endfunction

  function automatic int dcnt(input int c);
    if (c == 0) return dq0.size();
    if (c == 2) return dq2.size();
    return 0;
  endfunction

  function automatic logic [127:0] hhead(input int c);
    logic [127:0] h;
    h = '0;
    if (c == 0 && hq0.size() > 0) h = hq0[0];
    if (c == 1 && hq1.size() > 0) h = hq1[0];
    if (c == 2 && hq2.size() > 0) h = hq2[0];
    return h;
  endfunction

  function automatic logic [255:0] dhead(input int c);
    logic [255:0] d;
    d = '0;
    if (c == 0 && dq0.size() > 0) d = dq0[0];
    if (c == 2 && dq2.size() > 0) d = dq2[0];
    return d;
  endfunction

  function automatic int nbeats(input logic [127:0] h);
    int l;
    l = int'(h[9:0]);
    if (l == 0) l = 1024;
    return (l + 7) / 8;
  endfunction

  task automatic refresh();
    logic [127:0] t;
    p_he  = (hq0.size() == 0); p_hd  = hhead(0);
    np_he = (hq1.size() == 0); np_hd = hhead(1);
    t     = hhead(2);
    c_he  = (hq2.size() == 0); c_hd  = t[95:0];
    p_de  = (dq0.size() == 0); p_dd  = dhead(0);
    c_de  = (dq2.size() == 0); c_dd  = dhead(2);
  endtask

  task automatic push_hdr(input int c, input logic hasd, input int len);
    logic [127:0] h;
    h = {$urandom, $urandom, $urandom, $urandom};
    if (c == 2) h[127:96] = '0;
    h[30]  = hasd;
    h[9:0] = 10'(len);
    if (c == 0) hq0.push_back(h);
    if (c == 1) hq1.push_back(h);
    if (c == 2) hq2.push_back(h);
    if (hasd && c == 0) debt0 += nbeats(h);
    if (hasd && c == 2) debt2 += nbeats(h);
    refresh();
  endtask

  task automatic push_data(input int c);
    logic [255:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    if (c == 0) begin dq0.push_back(w); if (debt0 > 0) debt0--; end
    if (c == 2) begin dq2.push_back(w); if (debt2 > 0) debt2--; end
    refresh();
  endtask

  function automatic bit elig(input int c);
    logic [127:0] h;
    logic cok;
    cok = (c == 0) ? p_cok : (c == 1) ? np_cok : c_cok;
    if (link !== 1'b1 || cok !== 1'b1 || hcnt(c) == 0) return 1'b0;
    h = hhead(c);
    if (c == 1 || !h[30]) return 1'b1;
    return dcnt(c) > 0;
  endfunction

  task automatic model_reset();
    m_hp = 1'b0; m_cls = 0; m_left = 0; m_ptr = 0;
  endtask

  task automatic model_check();
    logic [2:0]   e_req;
    logic [255:0] e_tlp;
    logic [4:0]   e_rd;
    logic [1:0]   e_sent;
    logic [127:0] h;
    bit           got;
    e_req = 3'd0; e_tlp = '0; e_rd = 5'd0; e_sent = 2'd0; got = 1'b0;
    if (m_hp) begin
      h     = hhead(m_cls);
      e_req = (m_cls == 0) ? 3'd1 : (m_cls == 1) ? 3'd3 : 3'd5;
      e_tlp = {128'b0, h};
      if (ready) begin
        e_rd[(m_cls == 0) ? 0 : (m_cls == 1) ? 2 : 3] = 1'b1;
        m_hp   = 1'b0;
        m_left = (m_cls != 1 && h[30]) ? nbeats(h) : 0;
        if (m_cls != 1 && m_left == 0) e_sent[(m_cls == 0) ? 0 : 1] = 1'b1;
      end
    end else if (m_left > 0) begin
      if (dcnt(m_cls) > 0) begin
        e_req = (m_cls == 0) ? 3'd2 : 3'd6;
        e_tlp = dhead(m_cls);
        if (ready) begin
          e_rd[(m_cls == 0) ? 1 : 4] = 1'b1;
          m_left--;
          if (m_left == 0) e_sent[(m_cls == 0) ? 0 : 1] = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        int c;
        c = (m_ptr + k) % 3;
        if (!got && elig(c)) begin
          got = 1'b1; m_cls = c; m_hp = 1'b1; m_ptr = (c + 1) % 3;
        end
      end
    end
    chk("model_req",  256'(s_req),  256'(e_req));
    chk("model_tlp",  s_tlp,        e_tlp);
    chk("model_rden", 256'(s_rd),   256'(e_rd));
    chk("model_sent", 256'(s_sent), 256'(e_sent));
  endtask

  // One clock: sample and check on the falling edge, then let the FIFOs pop
  // just after the rising edge.
  task automatic step();
    @(negedge clk);
    s_req  = req;
    s_tlp  = tlp;
    s_rd   = {c_dr, c_hr, np_hr, p_dr, p_hr};
    s_sent = {c_sent, p_sent};
    if (!rst) model_check();
    @(posedge clk);
    #1;
    if (rst) model_reset();
    if (s_rd[0] && hq0.size() > 0) void'(hq0.pop_front());
    if (s_rd[1] && dq0.size() > 0) void'(dq0.pop_front());
    if (s_rd[2] && hq1.size() > 0) void'(hq1.pop_front());
    if (s_rd[3] && hq2.size() > 0) void'(hq2.pop_front());
    if (s_rd[4] && dq2.size() > 0) void'(dq2.pop_front());
    refresh();
  endtask

  typedef struct {
    logic       rdy;
    logic [2:0] req;
    logic [4:0] rd;
    logic [1:0] sent;
    int         sel;   // expected beat: 0 zero, 1 header, 2 data0, 3 data1
  } vec_t;

  initial begin
    vec_t         tv[7];
    int           order[$];
    int           exp2[4];
    logic [127:0] th;
    logic [255:0] td0, td1, exp_tlp;
    int           n, cnt_a, cnt_b, cnt_c;
    bit           done;

    tv[0] = '{1'b1, 3'd0, 5'b00000, 2'b00, 0};
    tv[1] = '{1'b0, 3'd1, 5'b00000, 2'b00, 1};
    tv[2] = '{1'b1, 3'd1, 5'b00001, 2'b00, 1};
    tv[3] = '{1'b0, 3'd2, 5'b00000, 2'b00, 2};
    tv[4] = '{1'b1, 3'd2, 5'b00010, 2'b00, 2};
    tv[5] = '{1'b1, 3'd2, 5'b00010, 2'b01, 3};
    tv[6] = '{1'b1, 3'd0, 5'b00000, 2'b00, 0};
    exp2  = '{1, 3, 5, 1};

    rst = 1'b1; link = 1'b1; ready = 1'b1; p_cok = 1'b1; np_cok = 1'b1; c_cok = 1'b1;
    model_reset();
    refresh();

    // Reset state
    step();
    step();
    chk("reset_req",  256'(s_req),  256'(0));
    chk("reset_tlp",  s_tlp,        256'(0));
    chk("reset_rden", 256'(s_rd),   256'(0));
    chk("reset_sent", 256'(s_sent), 256'(0));
    rst = 1'b0;

    // Round-robin order from reset: P, NP, CPL, P
    push_hdr(0, 1'b1, 8); push_data(0);
    push_hdr(1, 1'b0, 1);
    push_hdr(2, 1'b1, 8); push_data(2);
    push_hdr(0, 1'b0, 4);
    for (int i = 0; i < 40; i++) begin
      step();
      if (s_rd[0]) order.push_back(1);
      if (s_rd[2]) order.push_back(3);
      if (s_rd[3]) order.push_back(5);
    end
    chk("rr_count", 256'(order.size()), 256'(4));
    for (int i = 0; i < 4; i++) begin
      n = (i < order.size()) ? order[i] : -1;
      chk("rr_order", 256'(n), 256'(exp2[i]));
    end

    // Table: P len=16 (2 beats) with stalls in HDR and DATA
    push_hdr(0, 1'b1, 16); push_data(0); push_data(0);
    th = hq0[0]; td0 = dq0[0]; td1 = dq0[1];
    for (int i = 0; i < 7; i++) begin
      ready = tv[i].rdy;
      step();
      exp_tlp = (tv[i].sel == 1) ? {128'b0, th} : (tv[i].sel == 2) ? td0 :
                (tv[i].sel == 3) ? td1 : 256'(0);
      chk("tv_req",  256'(s_req),  256'(tv[i].req));
      chk("tv_rden", 256'(s_rd),   256'(tv[i].rd));
      chk("tv_sent", 256'(s_sent), 256'(tv[i].sent));
      chk("tv_tlp",  s_tlp,        exp_tlp);
    end
    ready = 1'b1;

    // Length 0 encodes 1024 DW -> 128 data beats
    push_hdr(0, 1'b1, 0);
    for (int i = 0; i < 128; i++) push_data(0);
    cnt_a = 0; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      if (s_rd[1]) cnt_a++;
      if (s_sent[0]) done = 1'b1;
    end
    chk("len0_sent_seen", 256'(done),  256'(1));
    chk("len0_beats",     256'(cnt_a), 256'(128));

    // Stall in DATA holds the beat; empty data FIFO gives a bubble
    push_hdr(2, 1'b1, 16); push_data(2);
    td0 = dq2[0];
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      step();
      if (s_req == 3'd5) done = 1'b1;
    end
    chk("stall_hdr_seen", 256'(done), 256'(1));
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_req",  256'(s_req), 256'(6));
      chk("stall_tlp",  s_tlp,       td0);
      chk("stall_rden", 256'(s_rd),  256'(0));
    end
    ready = 1'b1;
    step();
    chk("stall_pop", 256'(s_rd), 256'(5'b10000));
    step();
    chk("bubble_req",  256'(s_req), 256'(0));
    chk("bubble_tlp",  s_tlp,       256'(0));
    chk("bubble_rden", 256'(s_rd),  256'(0));
    push_data(2);
    step();
    chk("bubble_last_sent", 256'(s_sent), 256'(2'b10));
    step();

    // NP without credit is never granted while P and CPL proceed
    np_cok = 1'b0;
    push_hdr(1, 1'b0, 2);
    push_hdr(0, 1'b1, 8); push_data(0);
    push_hdr(2, 1'b1, 8); push_data(2);
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (s_rd[2]) cnt_a++;
      if (s_sent[0]) cnt_b++;
      if (s_sent[1]) cnt_c++;
    end
    chk("npcred_np_pops", 256'(cnt_a), 256'(0));
    chk("npcred_p_sent",  256'(cnt_b), 256'(1));
    chk("npcred_c_sent",  256'(cnt_c), 256'(1));
    np_cok = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_rd[2]) cnt_a++;
    end
    chk("npcred_np_after", 256'(cnt_a), 256'(1));

    // Reset mid-DATA, then link down blocks grants, then pointer is back at P
    push_hdr(0, 1'b1, 32);
    for (int i = 0; i < 4; i++) push_data(0);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if (s_req == 3'd2) done = 1'b1;
    end
    chk("rst_data_seen", 256'(done), 256'(1));
    rst = 1'b1; ready = 1'b0;
    step();
    rst = 1'b0; ready = 1'b1;
    hq0.delete(); hq1.delete(); hq2.delete(); dq0.delete(); dq2.delete();
    debt0 = 0; debt2 = 0;
    refresh();
    step();
    chk("rst_req",  256'(s_req), 256'(0));
    chk("rst_rden", 256'(s_rd),  256'(0));
    chk("rst_tlp",  s_tlp,       256'(0));
    link = 1'b0;
    push_hdr(1, 1'b0, 4); push_hdr(2, 1'b0, 4); push_hdr(0, 1'b0, 4);
    cnt_a = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_rd != 5'd0 || s_req != 3'd0) cnt_a++;
    end
    chk("linkdown_activity", 256'(cnt_a), 256'(0));
    link = 1'b1;
    done = 1'b0; n = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      step();
      if (s_req != 3'd0) begin done = 1'b1; n = int'(s_req); end
    end
    chk("rst_ptr_first_req", 256'(n), 256'(1));

    // Randomised traffic against the reference model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ready  = ($urandom_range(0, 3) != 0);
      link   = ($urandom_range(0, 19) != 0);
      p_cok  = ($urandom_range(0, 4) != 0);
      np_cok = ($urandom_range(0, 4) != 0);
      c_cok  = ($urandom_range(0, 4) != 0);
      for (int c = 0; c < 3; c++) begin
        if (hcnt(c) < 4 && $urandom_range(0, 9) == 0)
          push_hdr(c, (c == 1) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 5) != 0),
                   ($urandom_range(0, 49) == 0) ? 0 : int'($urandom_range(1, 40)));
      end
      if (debt0 > 0 && $urandom_range(0, 1) == 1) push_data(0);
      if (debt2 > 0 && $urandom_range(0, 1) == 1) push_data(2);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
